instr_fetch: RTL

//  Instruction fetch stage of the MIPS pipeline. It issues word requests to instruction memory
//  and holds returned words in a 1-entry skid buffer. It drives pc/instr into the decode stage
//  and resolves the redirects that decode raises (branch, J/JAL, JR), honouring the branch

---
 rtl/instr_fetch_if.sv | 11 +
 rtl/instr_fetch.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/instr_fetch_if.sv
// Instruction-memory request/response bus between the fetch stage (master) and imem (slave).
interface instr_fetch_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;

    modport master (output imem_req, imem_addr, input imem_ready, imem_rvalid, imem_rdata);
    modport slave  (input imem_req, imem_addr, output imem_ready, imem_rvalid, imem_rdata);
endinterface

// File: rtl/instr_fetch.sv
// MIPS fetch stage: single-outstanding imem requester, 1-entry skid buffer, ID register,
// and branch/jump redirect handling that always delivers the delay slot first.
module instr_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic          clk,
    input  logic          rst,
    instr_fetch_if.master imem,
    output logic [31:0]   pc_id,
    output logic [31:0]   instr_id,
    output logic          instr_valid,
    input  logic          stall,
    input  logic          jump_branch,
    input  logic          jump_target,
    input  logic          jump_reg,
    input  logic [31:0]   jr_pc
);
    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

    state_t          r_state, w_state_next;
    logic [XLEN-1:0] r_fetch_pc, r_req_pc, r_pending_target;
    logic [XLEN-1:0] r_buf_pc, r_buf_instr, r_pc_id, r_instr_id;
    logic            r_pending, r_buf_valid, r_instr_valid;

    logic            w_accept, w_resp, w_advance, w_resp_to_buf, w_redirect;
    logic [XLEN-1:0] w_p4, w_br_off, w_target;
    logic [XLEN-1:0] w_fetch_next, w_pending_target_next;
    logic            w_pending_next;
    logic            w_unused_jr;

    assign imem.imem_req  = (r_state == S_REQ);
    assign imem.imem_addr = r_fetch_pc;
    assign pc_id          = r_pc_id;
    assign instr_id       = r_instr_id;
    assign instr_valid    = r_instr_valid;
    assign w_unused_jr    = ^jr_pc[1:0];

    // Handshake qualifiers and redirect target selection
    always_comb begin
        w_accept      = (r_state == S_REQ) && imem.imem_ready;
        w_resp        = (r_state == S_WAIT) && imem.imem_rvalid;
        w_advance     = !r_instr_valid || !stall;
        w_resp_to_buf = w_resp && (!w_advance || r_buf_valid);
        w_redirect    = r_instr_valid && !stall && (jump_reg || jump_target || jump_branch);
        w_p4          = r_pc_id + XLEN'(4);
        w_br_off      = {{14{r_instr_id[15]}}, r_instr_id[15:0], 2'b00};
        w_target      = w_p4 + w_br_off;
        if (jump_reg) begin
            w_target = {jr_pc[31:2], 2'b00};
        end else if (jump_target) begin
            w_target = {w_p4[31:28], r_instr_id[25:0], 2'b00};
        end
    end

    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            S_IDLE:  if (!r_buf_valid) w_state_next = S_REQ;
            S_REQ:   if (imem.imem_ready) w_state_next = S_WAIT;
            S_WAIT:  if (imem.imem_rvalid) w_state_next = w_resp_to_buf ? S_IDLE : S_REQ;
            default: w_state_next = S_IDLE;
        endcase
    end

    // A redirect defers to the next accept only while the delay slot itself is still unrequested
    always_comb begin
        w_fetch_next          = r_fetch_pc;
        w_pending_next        = r_pending;
        w_pending_target_next = r_pending_target;
        if (w_accept) begin
            w_fetch_next   = r_pending ? r_pending_target : r_fetch_pc + XLEN'(4);
            w_pending_next = 1'b0;
        end
        if (w_redirect) begin
            if ((r_fetch_pc == w_p4) && !w_accept) begin
                w_pending_next        = 1'b1;
                w_pending_target_next = w_target;
            end else begin
                w_fetch_next = w_target;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_fetch_pc       <= RESET_PC;
            r_req_pc         <= RESET_PC;
            r_pending        <= 1'b0;
            r_pending_target <= RESET_PC;
        end else begin
            r_fetch_pc       <= w_fetch_next;
            r_pending        <= w_pending_next;
            r_pending_target <= w_pending_target_next;
            if (w_accept) begin
                r_req_pc <= r_fetch_pc;
            end
        end
    end

    // ID register fed from buffer, then live response, else bubble; skid buffer catches the rest
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc_id       <= RESET_PC;
            r_instr_id    <= '0;
            r_instr_valid <= 1'b0;
            r_buf_valid   <= 1'b0;
            r_buf_pc      <= RESET_PC;
            r_buf_instr   <= '0;
        end else begin
            if (w_advance) begin
                if (r_buf_valid) begin
                    r_pc_id       <= r_buf_pc;
                    r_instr_id    <= r_buf_instr;
                    r_instr_valid <= 1'b1;
                end else if (w_resp) begin
                    r_pc_id       <= r_req_pc;
                    r_instr_id    <= imem.imem_rdata;
                    r_instr_valid <= 1'b1;
                end else begin
                    r_instr_id    <= '0;
                    r_instr_valid <= 1'b0;
                end
            end
            if (w_resp_to_buf) begin
                r_buf_valid <= 1'b1;
                r_buf_pc    <= r_req_pc;
                r_buf_instr <= imem.imem_rdata;
            end else if (w_advance && r_buf_valid) begin
                r_buf_valid <= 1'b0;
            end
        end
    end
endmodule
